// File: rtl/seg_pkg.sv
// Shared glyph constants, scanner state and decoded-entry type for the
// seven-segment scan reader.
package seg_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, WAIT} state_t;

  typedef struct packed {
    logic [3:0] value;
    logic       blank;
    logic       err;
  } seg_entry_t;

endpackage

// File: rtl/seg_pattern_encoder.sv
// Reverse glyph decode: active-low segment pattern to hex value / blank / err.
module seg_pattern_encoder
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output seg_entry_t entry_c
);

  always_comb begin
    entry_c = '0;
    case (seg)
      SEG_0:     entry_c.value = 4'h0;
      SEG_1:     entry_c.value = 4'h1;
      SEG_2:     entry_c.value = 4'h2;
      SEG_3:     entry_c.value = 4'h3;
      SEG_4:     entry_c.value = 4'h4;
      SEG_5:     entry_c.value = 4'h5;
      SEG_6:     entry_c.value = 4'h6;
      SEG_7:     entry_c.value = 4'h7;
      SEG_8:     entry_c.value = 4'h8;
      SEG_9:     entry_c.value = 4'h9;
      SEG_A:     entry_c.value = 4'hA;
      SEG_B:     entry_c.value = 4'hB;
      SEG_C:     entry_c.value = 4'hC;
      SEG_D:     entry_c.value = 4'hD;
      SEG_E:     entry_c.value = 4'hE;
      SEG_F:     entry_c.value = 4'hF;
      SEG_BLANK: entry_c.blank = 1'b1;
      default:   entry_c.err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg_scan_reader.sv
// Observes a multiplexed active-low 7-segment bus, debounces each position
// across scans and offers the committed digits as a valid/ready snapshot.
module seg_scan_reader
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS       = 4,
  parameter int unsigned SETTLE_CYC   = 4,
  parameter int unsigned STABLE_SCANS = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIGITS-1:0]     an,
  input  logic [6:0]            seg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_digits,
  output logic [DIGITS-1:0]     out_blank,
  output logic [DIGITS-1:0]     out_err,
  output logic [DIGITS-1:0]     out_known
);

  localparam int unsigned CNT_W = $clog2(STABLE_SCANS + 1);
  localparam int unsigned POS_W = $clog2(DIGITS);
  localparam int unsigned SET_W = 8;

  logic [DIGITS-1:0] an_q, an_prev;
  logic [6:0]        seg_q, seg_prev;
  state_t            state;
  logic [SET_W-1:0]  settle_cnt;

  seg_entry_t        cand     [DIGITS];
  seg_entry_t        stable_q [DIGITS];
  logic [CNT_W-1:0]  cnt      [DIGITS];
  logic [DIGITS-1:0] known;
  logic              dirty;

  seg_entry_t        dec_c;
  logic              legal_c, changed_c, an_changed_c, sample_fire_c;
  logic              commit_c, fresh_c, load_c;
  logic [POS_W-1:0]  pos_c;
  logic [CNT_W-1:0]  cnt_next_c;

  // Input capture plus one-cycle history for change detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_q     <= '1;
      an_prev  <= '1;
      seg_q    <= '1;
      seg_prev <= '1;
    end else begin
      an_q     <= an;
      an_prev  <= an_q;
      seg_q    <= seg;
      seg_prev <= seg_q;
    end
  end

  seg_pattern_encoder u_enc (
    .seg     (seg_q),
    .entry_c (dec_c)
  );

  assign legal_c      = $onehot(~an_q);
  assign an_changed_c = (an_q != an_prev);
  assign changed_c    = an_changed_c || (seg_q != seg_prev);

  always_comb begin
    pos_c = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!an_q[i]) pos_c = POS_W'(i);
    end
  end

  // A bus change during SAMPLE means the dwell ended early: drop the sample
  assign sample_fire_c = (state == SAMPLE) && !changed_c;

  // Scan tracker: one sample per anode dwell once the bus has settled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      settle_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (legal_c) begin
            settle_cnt <= '0;
            state      <= SETTLE;
          end
        end
        SETTLE: begin
          if (changed_c) begin
            settle_cnt <= '0;
            if (!legal_c) state <= IDLE;
          end else if (settle_cnt == SET_W'(SETTLE_CYC - 1)) begin
            state <= SAMPLE;
          end else begin
            settle_cnt <= settle_cnt + SET_W'(1);
          end
        end
        SAMPLE: begin
          settle_cnt <= '0;
          if (changed_c) state <= legal_c ? SETTLE : IDLE;
          else           state <= WAIT;
        end
        WAIT: begin
          if (an_changed_c) begin
            settle_cnt <= '0;
            state      <= legal_c ? SETTLE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Debounce: count consecutive identical samples, saturating
  always_comb begin
    cnt_next_c = CNT_W'(1);
    if (dec_c == cand[pos_c]) begin
      cnt_next_c = (cnt[pos_c] >= CNT_W'(STABLE_SCANS)) ? cnt[pos_c]
                                                       : cnt[pos_c] + CNT_W'(1);
    end
  end

  assign commit_c = sample_fire_c && (cnt_next_c == CNT_W'(STABLE_SCANS));
  assign fresh_c  = commit_c && (!known[pos_c] || (stable_q[pos_c] != dec_c));
  assign load_c   = dirty && (!out_valid || out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIGITS; i++) begin
        cand[i]     <= '0;
        stable_q[i] <= '0;
        cnt[i]      <= '0;
      end
      known <= '0;
    end else if (sample_fire_c) begin
      cand[pos_c] <= dec_c;
      cnt[pos_c]  <= cnt_next_c;
      if (commit_c) begin
        stable_q[pos_c] <= dec_c;
        known[pos_c]    <= 1'b1;
      end
    end
  end

  // Snapshot register: reloads only when free or being consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_digits <= '0;
      out_blank  <= '0;
      out_err    <= '0;
      out_known  <= '0;
      dirty      <= 1'b0;
    end else begin
      dirty <= (dirty && !load_c) || fresh_c;
      if (load_c) begin
        out_valid <= 1'b1;
        out_known <= known;
        for (int i = 0; i < DIGITS; i++) begin
          out_digits[4*i +: 4] <= stable_q[i].value;
          out_blank[i]         <= stable_q[i].blank;
          out_err[i]           <= stable_q[i].err;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench: expected snapshots are queued by the stimulus and checked
// by a monitor on every valid/ready transfer.
module tb_seg_scan_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        out_valid, out_ready;
  logic [15:0] out_digits;
  logic [3:0]  out_blank, out_err, out_known;

  typedef struct {
    logic [15:0] d;
    logic [3:0]  b;
    logic [3:0]  e;
    logic [3:0]  k;
  } snap_t;

  snap_t q[$];
  snap_t x;
  int    checks = 0;
  int    errors = 0;

  seg_scan_reader #(.DIGITS(4), .SETTLE_CYC(4), .STABLE_SCANS(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .an         (an),
    .seg        (seg),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_digits (out_digits),
    .out_blank  (out_blank),
    .out_err    (out_err),
    .out_known  (out_known)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dwell(input int p, input logic [6:0] s, input int n);
    an    = 4'hF;
    an[p] = 1'b0;
    seg   = s;
    repeat (n) tick();
  endtask

  task automatic dwell_glitch(input int p, input logic [6:0] s, input logic [6:0] g, input int n);
    an    = 4'hF;
    an[p] = 1'b0;
    seg   = s;
    tick();
    tick();
    seg = g;
    tick();
    seg = s;
    repeat (n - 3) tick();
  endtask

  task automatic scan(input logic [6:0] s3, input logic [6:0] s2, input logic [6:0] s1, input logic [6:0] s0);
    dwell(3, s3, 8);
    dwell(2, s2, 8);
    dwell(1, s1, 8);
    dwell(0, s0, 8);
  endtask

  task automatic expect_snap(input logic [15:0] d, input logic [3:0] b, input logic [3:0] e, input logic [3:0] k);
    snap_t s;
    s.d = d; s.b = b; s.e = e; s.k = k;
    q.push_back(s);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      tick();
      n++;
    end
    check(name, 32'(q.size()), 32'd0);
  endtask

  // Monitor: every accepted snapshot must match the oldest expectation
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_snapshot: got digits %h blank %h err %h known %h, none expected",
                 out_digits, out_blank, out_err, out_known);
      end else begin
        x = q.pop_front();
        if ({out_digits, out_blank, out_err, out_known} !== {x.d, x.b, x.e, x.k}) begin
          errors++;
          $display("FAIL snapshot: got digits %h blank %h err %h known %h, expected digits %h blank %h err %h known %h",
                   out_digits, out_blank, out_err, out_known, x.d, x.b, x.e, x.k);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    an        = 4'hF;
    seg       = 7'h7F;
    out_ready = 1'b1;
    rst_n     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_outputs", 32'({out_digits, out_blank, out_err, out_known}), 32'd0);
    rst_n = 1'b1;

    // Idle with no anode selected
    seen = 1'b0;
    repeat (100) begin
      tick();
      seen = seen | out_valid | (|{out_digits, out_blank, out_err, out_known});
    end
    check("idle_quiet", 32'(seen), 32'd0);

    // "1234": positions commit in scan order on the third scan
    expect_snap(16'h1000, 4'h0, 4'h0, 4'h8);
    expect_snap(16'h1200, 4'h0, 4'h0, 4'hC);
    expect_snap(16'h1230, 4'h0, 4'h0, 4'hE);
    expect_snap(16'h1234, 4'h0, 4'h0, 4'hF);
    scan(7'h79, 7'h24, 7'h30, 7'h19);
    scan(7'h79, 7'h24, 7'h30, 7'h19);
    dwell(3, 7'h79, 8);
    dwell(2, 7'h24, 8);
    dwell(1, 7'h30, 8);
    an = 4'b1110; seg = 7'h19;
    tick(); tick();
    out_ready = 1'b0;
    repeat (6) tick();
    check("scan_valid", 32'(out_valid), 32'd1);
    check("scan_digits", 32'(out_digits), 32'h1234);
    check("scan_known", 32'(out_known), 32'hF);

    // Backpressure: new commit must not disturb the presented snapshot
    repeat (3) scan(7'h79, 7'h24, 7'h30, 7'h0E);
    check("held_valid", 32'(out_valid), 32'd1);
    check("held_digits", 32'(out_digits), 32'h1234);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("reload_valid", 32'(out_valid), 32'd1);
    check("reload_digits", 32'(out_digits), 32'h123F);
    expect_snap(16'h123F, 4'h0, 4'h0, 4'hF);
    out_ready = 1'b1;
    drain("drain_backpressure");

    // Flicker on position 2 never commits
    scan(7'h79, 7'h30, 7'h30, 7'h0E);
    scan(7'h79, 7'h24, 7'h30, 7'h0E);
    scan(7'h79, 7'h30, 7'h30, 7'h0E);
    scan(7'h79, 7'h24, 7'h30, 7'h0E);
    check("flicker_digits", 32'(out_digits), 32'h123F);
    check("flicker_valid", 32'(out_valid), 32'd0);

    // One-cycle glitch inside a long dwell still yields the real glyph
    expect_snap(16'h125F, 4'h0, 4'h0, 4'hF);
    repeat (3) begin
      dwell(3, 7'h79, 8);
      dwell(2, 7'h24, 8);
      dwell_glitch(1, 7'h12, 7'h00, 16);
      dwell(0, 7'h0E, 8);
    end
    drain("drain_glitch");

    // Blank then unrecognised pattern on position 1
    expect_snap(16'h120F, 4'b0010, 4'h0, 4'hF);
    repeat (3) scan(7'h79, 7'h24, 7'h7F, 7'h0E);
    drain("drain_blank");
    expect_snap(16'h120F, 4'h0, 4'b0010, 4'hF);
    repeat (3) scan(7'h79, 7'h24, 7'h55, 7'h0E);
    drain("drain_err");

    // Illegal anode between the 2nd and 3rd scan must not reset position 0
    repeat (2) scan(7'h79, 7'h24, 7'h55, 7'h46);
    an = 4'b1100; seg = 7'h00;
    repeat (20) tick();
    dwell(3, 7'h79, 8);
    dwell(2, 7'h24, 8);
    dwell(1, 7'h55, 8);
    an = 4'b1110; seg = 7'h46;
    tick(); tick();
    out_ready = 1'b0;
    repeat (6) tick();
    check("illegal_valid", 32'(out_valid), 32'd1);
    check("illegal_digits", 32'(out_digits), 32'h120C);
    check("illegal_err", 32'(out_err), 32'h2);

    // Asynchronous reset while a snapshot is held
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(out_valid), 32'd0);
    check("async_reset_known", 32'(out_known), 32'd0);
    an = 4'hF; seg = 7'h7F; out_ready = 1'b1;
    tick(); tick();
    rst_n = 1'b1;
    expect_snap(16'h1000, 4'h0, 4'h0, 4'h8);
    expect_snap(16'h1200, 4'h0, 4'h0, 4'hC);
    expect_snap(16'h1200, 4'h0, 4'b0010, 4'hE);
    expect_snap(16'h120C, 4'h0, 4'b0010, 4'hF);
    repeat (2) scan(7'h79, 7'h24, 7'h55, 7'h46);
    check("no_early_commit", 32'(q.size()), 32'd4);
    scan(7'h79, 7'h24, 7'h55, 7'h46);
    drain("drain_recovery");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
